// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: clear-engine state
// encoding, address-width helper and default geometry used by decode/writeback.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    // Address width for a file of n entries; never narrower than one bit.
    function automatic int unsigned calc_aw(input int unsigned n);
        int unsigned aw;
        aw = $clog2(n);
        return (aw < 1) ? 1 : aw;
    endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear engine: sweeps every entry to zero after reset or on clr_req, one
// entry per cycle, and reports busy while the sweep is in progress.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          init_busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    rf_state_e     state_q;
    logic [AW-1:0] clr_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
        end else begin
            unique case (state_q)
                RF_IDLE: begin
                    if (clr_req) begin
                        state_q   <= RF_CLEAR;
                        clr_idx_q <= '0;
                    end
                end
                RF_CLEAR: begin
                    // Counter wraps to 0 naturally since NREGS is a power of two.
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == AW'(NREGS - 1)) begin
                        state_q <= RF_IDLE;
                    end
                end
                default: begin
                    state_q   <= RF_CLEAR;
                    clr_idx_q <= '0;
                end
            endcase
        end
    end

    assign init_busy = (state_q == RF_CLEAR);
    assign clr_we    = init_busy;
    assign clr_addr  = clr_idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with same-cycle bypass,
// highest-port-wins write priority and a sequential clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = calc_aw(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic              clr_req,
    output logic              init_busy,
    output logic              wr_conflict
);

    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic [NWR-1:0]  wr_ok;
    logic [NWR-1:0]  wr_take;
    logic            conflict_d;
    logic            wr_conflict_q;
    logic [XLEN-1:0] mem_q [NREGS];

    regfile_clr_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clr_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // wr_ok: legal write seen by bypass/conflict; wr_take: also survives a clear request.
    always_comb begin
        wr_ok   = '0;
        wr_take = '0;
        for (int w = 0; w < NWR; w++) begin
            wr_ok[w]   = wr_en[w] && !init_busy &&
                         !(ZERO_REG && (wr_addr[w*AW +: AW] == '0));
            wr_take[w] = wr_ok[w] && !clr_req;
        end
    end

    // Later loop iterations override earlier ones, so the highest port wins.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_take[w]) begin
                    mem_q[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    generate
        if (NWR > 1) begin : g_conflict
            assign conflict_d = wr_ok[0] && wr_ok[1] &&
                                (wr_addr[0 +: AW] == wr_addr[AW +: AW]);
        end else begin : g_no_conflict
            assign conflict_d = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_conflict_q <= 1'b0;
        end else begin
            wr_conflict_q <= conflict_d;
        end
    end

    assign wr_conflict = wr_conflict_q;

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rv;

        assign ra = rd_addr[r*AW +: AW];

        always_comb begin
            rv = mem_q[ra];
            if (BYPASS) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_ok[w] && (wr_addr[w*AW +: AW] == ra)) begin
                        rv = wr_data[w*XLEN +: XLEN];
                    end
                end
            end
            if (init_busy || (ZERO_REG && (ra == '0))) begin
                rv = '0;
            end
        end

        assign rd_data[r*XLEN +: XLEN] = rv;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default instance (bypass, zero reg) and a
// BYPASS=0/ZERO_REG=0 instance share stimulus and are checked side by side.
module tb_regfile_mp;

    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2*AW-1:0] rd_addr;
    logic [63:0]   rd_a, rd_b;
    logic [1:0]    wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic          clr_req;
    logic          busy_a, busy_b, conf_a, conf_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_a),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clr_req     (clr_req),
        .init_busy   (busy_a),
        .wr_conflict (conf_a)
    );

    regfile_mp #(
        .BYPASS   (1'b0),
        .ZERO_REG (1'b0)
    ) dut_nb (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_b),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clr_req     (clr_req),
        .init_busy   (busy_b),
        .wr_conflict (conf_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 2'b00;
        wr_addr = '0;
        wr_data = '0;
        clr_req = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        idle();
        rd_addr = {5'd7, 5'd3};
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy_a); end
        checks++; if (conf_a !== 1'b0 || conf_b !== 1'b0) begin failures++; $display("FAIL reset_conflict got=%b/%b exp=0", conf_a, conf_b); end
        checks++; if (rd_a !== 64'h0 || rd_b !== 64'h0) begin failures++; $display("FAIL reset_rd got=%h/%h exp=0", rd_a, rd_b); end
        rst_n = 1'b1;
        n = 0;
        while (n < 100) begin
            step();
            n++;
            if (!busy_a) break;
        end
        checks++; if (n !== 32) begin failures++; $display("FAIL reset_clear_edges got=%0d exp=32", n); end
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL reset_busy_nb got=%b exp=0", busy_b); end
        for (int a = 0; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            checks++;
            if (rd_a !== 64'h0 || rd_b !== 64'h0) begin
                failures++; $display("FAIL reset_sweep addr=%0d got=%h/%h exp=0", a, rd_a, rd_b);
            end
        end
    endtask

    task automatic test_bypass();
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd5};
        wr_data = {32'h0, 32'hDEAD_BEEF};
        rd_addr = {5'd5, 5'd0};
        #1;
        checks++; if (rd_a[63:32] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_same_cycle got=%h exp=deadbeef", rd_a[63:32]); end
        checks++; if (rd_b[63:32] !== 32'h0) begin failures++; $display("FAIL nobypass_same_cycle got=%h exp=0", rd_b[63:32]); end
        step();
        idle();
        #1;
        checks++; if (rd_a[63:32] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_next got=%h exp=deadbeef", rd_a[63:32]); end
        checks++; if (rd_b[63:32] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL nobypass_next got=%h exp=deadbeef", rd_b[63:32]); end
    endtask

    task automatic test_back_to_back();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'h0000_0001};
        rd_addr = {5'd10, 5'd10};
        step();
        wr_data = {32'h0, 32'h0000_0002};
        #1;
        checks++; if (rd_a[31:0] !== 32'h2) begin failures++; $display("FAIL b2b_bypass got=%h exp=2", rd_a[31:0]); end
        checks++; if (rd_b[31:0] !== 32'h1) begin failures++; $display("FAIL b2b_old got=%h exp=1", rd_b[31:0]); end
        step();
        idle();
        #1;
        checks++; if (rd_a[31:0] !== 32'h2 || rd_b[31:0] !== 32'h2) begin failures++; $display("FAIL b2b_final got=%h/%h exp=2", rd_a[31:0], rd_b[31:0]); end
    endtask

    task automatic test_conflict();
        wr_en   = 2'b11;
        wr_addr = {5'd7, 5'd7};
        wr_data = {32'h2222_2222, 32'h1111_1111};
        rd_addr = {5'd7, 5'd7};
        #1;
        checks++; if (conf_a !== 1'b0) begin failures++; $display("FAIL conflict_early got=%b exp=0", conf_a); end
        checks++; if (rd_a[63:32] !== 32'h2222_2222) begin failures++; $display("FAIL conflict_bypass got=%h exp=22222222", rd_a[63:32]); end
        step();
        idle();
        #1;
        checks++; if (conf_a !== 1'b1 || conf_b !== 1'b1) begin failures++; $display("FAIL conflict_flag got=%b/%b exp=1", conf_a, conf_b); end
        checks++; if (rd_a[31:0] !== 32'h2222_2222 || rd_b[31:0] !== 32'h2222_2222) begin failures++; $display("FAIL conflict_winner got=%h/%h exp=22222222", rd_a[31:0], rd_b[31:0]); end
        step();
        checks++; if (conf_a !== 1'b0) begin failures++; $display("FAIL conflict_pulse got=%b exp=0", conf_a); end
    endtask

    task automatic test_zero_reg();
        wr_en   = 2'b11;
        wr_addr = {5'd0, 5'd0};
        wr_data = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        rd_addr = {5'd0, 5'd0};
        #1;
        checks++; if (rd_a[31:0] !== 32'h0) begin failures++; $display("FAIL zero_same_cycle got=%h exp=0", rd_a[31:0]); end
        step();
        idle();
        #1;
        checks++; if (conf_a !== 1'b0) begin failures++; $display("FAIL zero_conflict got=%b exp=0", conf_a); end
        checks++; if (conf_b !== 1'b1) begin failures++; $display("FAIL nozero_conflict got=%b exp=1", conf_b); end
        checks++; if (rd_a[31:0] !== 32'h0) begin failures++; $display("FAIL zero_read got=%h exp=0", rd_a[31:0]); end
        checks++; if (rd_b[31:0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL nozero_read got=%h exp=ffffffff", rd_b[31:0]); end
        step();
    endtask

    task automatic test_reset_mid_op();
        int n;
        wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h0000_000B, 32'h0000_000A};
        rd_addr = {5'd9, 5'd9};
        step();
        idle();
        checks++; if (conf_a !== 1'b1) begin failures++; $display("FAIL midop_conflict got=%b exp=1", conf_a); end
        rst_n = 1'b0;
        #1;
        checks++; if (conf_a !== 1'b0 || busy_a !== 1'b1) begin failures++; $display("FAIL midop_async got=conf%b busy%b exp=conf0 busy1", conf_a, busy_a); end
        checks++; if (rd_a !== 64'h0) begin failures++; $display("FAIL midop_rd got=%h exp=0", rd_a); end
        rst_n = 1'b1;
        n = 0;
        while (n < 100) begin
            step();
            n++;
            if (!busy_a) break;
        end
        checks++; if (n !== 32) begin failures++; $display("FAIL midop_clear_edges got=%0d exp=32", n); end
        checks++; if (rd_a !== 64'h0 || rd_b !== 64'h0) begin failures++; $display("FAIL midop_swept got=%h/%h exp=0", rd_a, rd_b); end
    endtask

    task automatic test_clear();
        int n;
        for (int i = 1; i < 32; i += 2) begin
            wr_en   = (i < 31) ? 2'b11 : 2'b01;
            wr_addr = {5'((i + 1) % 32), 5'(i)};
            wr_data = {32'hA500_0000 | 32'(i + 1), 32'hA500_0000 | 32'(i)};
            step();
        end
        idle();
        rd_addr = {5'd31, 5'd3};
        #1;
        checks++; if (rd_a[31:0] !== 32'hA500_0003 || rd_a[63:32] !== 32'hA500_001F) begin failures++; $display("FAIL fill got=%h exp=a500001fa5000003", rd_a); end
        clr_req = 1'b1;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'hBAD0_BAD0};
        step();
        checks++; if (busy_a !== 1'b1 || rd_a !== 64'h0) begin failures++; $display("FAIL clr_start got=busy%b rd%h exp=busy1 rd0", busy_a, rd_a); end
        n = 0;
        while (n < 100) begin
            wr_en   = 2'b11;
            wr_addr = {5'd9, 5'd4};
            wr_data = {32'h1234_5678, 32'h8765_4321};
            clr_req = (n == 10);
            step();
            n++;
            if (!busy_a) break;
        end
        idle();
        checks++; if (n !== 32) begin failures++; $display("FAIL clr_edges got=%0d exp=32", n); end
        for (int a = 0; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            checks++;
            if (rd_a !== 64'h0 || rd_b !== 64'h0) begin
                failures++; $display("FAIL clr_sweep addr=%0d got=%h/%h exp=0", a, rd_a, rd_b);
            end
        end
    endtask

    initial begin
        idle();
        rd_addr = '0;
        test_reset();
        test_bypass();
        test_back_to_back();
        test_conflict();
        test_zero_reg();
        test_reset_mid_op();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the core's decode/writeback path. It replaces the fixed 2-read/1-write 32x32 file with configurable width, depth and read/write port counts. Additions are same-cycle write-to-read bypass, deterministic multi-port write priority, and a sequential clear engine that zeroes the array after reset or on request. Decode reads it combinationally; writeback drives the write ports once its own commit qualification has been applied.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2); AW = log2(NREGS)
- NRD, 2, number of read ports (1..4)
- NWR, 2, number of write ports (1..2)
- ZERO_REG, 1, 1 = entry 0 is hardwired to zero
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
- wr_en  in  NWR  per-port write enable (already qualified by writeback commit)
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- clr_req  in  1  single-cycle request to zero the whole file
- init_busy  out  1  clear engine active; writes are ignored and reads return 0
- wr_conflict  out  1  registered one-cycle flag: two enabled write ports hit the same non-zero address

## Operation
- Storage: NREGS x XLEN array. The array is not asynchronously reset; its contents are established only by the clear engine.
- Clear FSM, two states:
  - IDLE→CLEAR on clr_req=1 while in IDLE. Reset also forces CLEAR.
  - CLEAR: counter clr_idx starts at 0. Each cycle, entry clr_idx is written with 0 and clr_idx increments.
  - CLEAR→IDLE on the cycle that writes entry NREGS-1. The counter wraps to 0.
- Reads are asynchronous, by address:
  - While init_busy=1, every rd_data port is 0.
  - With ZERO_REG=1, address 0 always reads 0.
- Writes are accepted only in IDLE, only with wr_en=1, and only to an address ≠ 0 when ZERO_REG=1. Writes are dropped entirely while in CLEAR.
- clr_req in the same cycle as a write in IDLE: the clear has priority and the write is dropped.
- clr_req while already in CLEAR is ignored; the sweep is not restarted.
- Same-address writes on ports 0 and 1: port 1 (the higher index) wins. wr_conflict pulses high for one cycle on the following edge. A conflict on address 0 with ZERO_REG=1 does not raise wr_conflict.
- Bypass, when BYPASS=1 and in IDLE: if any enabled write port matches rd_addr of port i (non-zero address when ZERO_REG=1), rd_data[i] takes that port's wr_data. The highest-index matching port wins. This is combinational within the same cycle.
- BYPASS=0: a read in the write cycle returns the old value; the new value is visible from the next cycle.

## Timing
- During reset (rst_n=0): state=CLEAR, clr_idx=0, init_busy=1, wr_conflict=0, all rd_data=0.
- Clear latency: init_busy stays high for exactly NREGS rising edges after rst_n deasserts. The first edge after deassertion clears entry 0. With NREGS=32, init_busy falls at edge 32, and the first write can be accepted at edge 33.
- clr_req sampled high at edge k: init_busy is 1 after edge k and returns to 0 after edge k+NREGS.
- Write latency: data on the write ports is stored at the edge. It is visible to non-bypassed reads immediately after that edge.
- Reset asserted mid-clear or mid-operation: state immediately returns to CLEAR with clr_idx=0, and the full sweep re-runs after release.
- wr_conflict: 0 or 1 for one cycle, one edge after the conflicting write cycle.

## Structure
- Shared package regfile_pkg holds:
  - the state encoding (RF_IDLE, RF_CLEAR)
  - the AW computation function
  - default XLEN/NREGS constants, shared with the decode and writeback stages.
- One sub-module is natural: regfile_clr_fsm, containing the state register, clr_idx counter and init_busy generation. It outputs the clear-write address and enable.
- The array, write-priority mux and bypass logic stay in regfile_mp.

## Test plan
- Reset release with NREGS=32: count edges while init_busy=1, expect exactly 32; then read every address, expect all 0.
- Write x5=0xDEADBEEF via port 0 and read it on port 1 in the same cycle:
  - BYPASS=1 returns 0xDEADBEEF in that cycle.
  - BYPASS=0 returns 0 in that cycle and 0xDEADBEEF in the next.
- Ports 0 and 1 both write x7 (0x11111111 and 0x22222222): x7 reads 0x22222222, and wr_conflict=1 for one cycle only.
- Write x0=0xFFFFFFFF with ZERO_REG=1: x0 reads 0 and wr_conflict stays 0. With ZERO_REG=0, x0 reads 0xFFFFFFFF.
- Fill x1..x31 with nonzero data, then pulse clr_req together with a write to x3:
  - The x3 write is dropped.
  - Writes presented during the next 32 cycles are ignored.
  - Afterwards all registers read 0.
- Assert rst_n=0 when clr_idx=10 during a clear, then release: init_busy stays high for a further full 32 edges.
